// File: rtl/main_mem_line_responder.sv
// Main-memory line responder: fixed-latency line read bursts and line write-backs over a word array.
// Optional feature macro MEM_RESP_STATS_EN adds rd_line_cnt / wr_line_cnt request counters.
module main_mem_line_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 13,
    parameter int LATENCY       = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_we,
    input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0]  req_line_addr,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       req_wdata,
    output logic                                   rd_valid,
    output logic [31:0]                            rd_data,
    output logic [LINE_ADDR_LEN-1:0]               rd_idx,
    output logic                                   rd_last,
    output logic                                   wr_done,
    output logic [1:0]                             fsm_state
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]                            rd_line_cnt,
    output logic [31:0]                            wr_line_cnt
`endif
);

    localparam int W         = 1 << LINE_ADDR_LEN;
    localparam int LA        = MEM_ADDR_LEN - LINE_ADDR_LEN;
    localparam int MEM_WORDS = 1 << MEM_ADDR_LEN;
    localparam int CW        = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RBURST, WBURST} state_t;

    state_t                   state;
    logic [CW-1:0]            wait_cnt;
    logic [LINE_ADDR_LEN-1:0] word_cnt;
    logic                     we_q;
    logic [LA-1:0]            line_q;
    logic [31:0]              wline_q [W];
    logic [31:0]              mem [0:MEM_WORDS-1];
    logic [MEM_ADDR_LEN-1:0]  mem_addr;
    logic                     accept;
    logic                     last_word;

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
    // the requester holds req_valid and its payload stable until then.
    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign mem_addr  = {line_q, word_cnt};
    assign last_word = (word_cnt == LINE_ADDR_LEN'(W - 1));
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            word_cnt <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            wr_done  <= 1'b0;
            rd_data  <= '0;
            rd_idx   <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            wr_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wait_cnt <= '0;
                        word_cnt <= '0;
                        if (LATENCY > 0) state <= WAIT;
                        else             state <= req_we ? WBURST : RBURST;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CW'(LATENCY - 1)) state <= we_q ? WBURST : RBURST;
                    else                             wait_cnt <= wait_cnt + CW'(1);
                end
                RBURST: begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[mem_addr];
                    rd_idx   <= word_cnt;
                    rd_last  <= last_word;
                    word_cnt <= word_cnt + LINE_ADDR_LEN'(1);
                    if (last_word) state <= IDLE;
                end
                WBURST: begin
                    word_cnt <= word_cnt + LINE_ADDR_LEN'(1);
                    if (last_word) begin
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request payload is captured once at accept so the requester is free afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q   <= req_we;
            line_q <= req_line_addr;
            for (int i = 0; i < W; i++) wline_q[i] <= req_wdata[32*i +: 32];
        end
    end

    // An async reset leaves the FSM in IDLE, so an aborted write stops committing at once.
    always_ff @(posedge clk) begin
        if (state == WBURST) mem[mem_addr] <= wline_q[word_cnt];
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_line_cnt <= '0;
            wr_line_cnt <= '0;
        end else if (accept) begin
            if (req_we) wr_line_cnt <= wr_line_cnt + 32'd1;
            else        rd_line_cnt <= rd_line_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_main_mem_line_responder.sv
// Bench for main_mem_line_responder: LATENCY=8 instance plus a LATENCY=0 instance,
// checked against a word-array model and the cycle timing of the line protocol.
module tb_main_mem_line_responder;

    localparam int LAL = 3;
    localparam int MAL = 13;
    localparam int LAT = 8;
    localparam int W   = 8;
    localparam int LA  = MAL - LAL;
    localparam int WD  = 32 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we;
    logic [LA-1:0] req_line_addr;
    logic [WD-1:0] req_wdata;
    logic          rd_valid, rd_last, wr_done;
    logic [31:0]   rd_data;
    logic [LAL-1:0] rd_idx;
    logic [1:0]    fsm_state;

    logic          z_req_valid, z_req_ready, z_req_we;
    logic [LA-1:0] z_req_line_addr;
    logic [WD-1:0] z_req_wdata;
    logic          z_rd_valid, z_rd_last, z_wr_done;
    logic [31:0]   z_rd_data;
    logic [LAL-1:0] z_rd_idx;
    logic [1:0]    z_fsm_state;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]   rd_line_cnt, wr_line_cnt, z_rd_line_cnt, z_wr_line_cnt;
`endif

    main_mem_line_responder #(.LINE_ADDR_LEN(LAL), .MEM_ADDR_LEN(MAL), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_line_addr(req_line_addr), .req_wdata(req_wdata), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_idx(rd_idx), .rd_last(rd_last), .wr_done(wr_done),
        .fsm_state(fsm_state)
`ifdef MEM_RESP_STATS_EN
        , .rd_line_cnt(rd_line_cnt), .wr_line_cnt(wr_line_cnt)
`endif
    );

    main_mem_line_responder #(.LINE_ADDR_LEN(LAL), .MEM_ADDR_LEN(MAL), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_line_addr(z_req_line_addr), .req_wdata(z_req_wdata), .rd_valid(z_rd_valid),
        .rd_data(z_rd_data), .rd_idx(z_rd_idx), .rd_last(z_rd_last), .wr_done(z_wr_done),
        .fsm_state(z_fsm_state)
`ifdef MEM_RESP_STATS_EN
        , .rd_line_cnt(z_rd_line_cnt), .wr_line_cnt(z_wr_line_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [int];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic        cap_rv [64];
    logic        cap_last [64];
    logic        cap_wd [64];
    logic        cap_rdy [64];
    logic [LAL-1:0] cap_idx [64];

    function automatic logic [WD-1:0] pack_line(input logic [31:0] base);
        logic [WD-1:0] d;
        for (int i = 0; i < W; i++) d[32*i +: 32] = base + 32'(i);
        return d;
    endfunction

    function automatic logic [WD-1:0] rand_line();
        logic [WD-1:0] d;
        for (int i = 0; i < W; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic void model_write(input logic [LA-1:0] line, input logic [WD-1:0] d);
        for (int i = 0; i < W; i++) model_mem[int'({line, 3'(i)})] = d[32*i +: 32];
    endfunction

    function automatic void expect_line(input logic [LA-1:0] line);
        for (int i = 0; i < W; i++) exp_q.push_back(model_mem[int'({line, 3'(i)})]);
    endfunction

    // Driver + monitor: issue one request, then record nsamp samples, sample n taken after edge T+n.
    task automatic issue(input logic we, input logic [LA-1:0] line, input logic [WD-1:0] d,
                         input int nsamp);
        int guard;
        guard = 0;
        req_valid = 1'b1; req_we = we; req_line_addr = line; req_wdata = d;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++; failures++;
            $display("FAIL accept_timeout line=%h got_ready=%b exp_ready=1", line, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_line_addr = LA'($urandom); req_wdata = {8{$urandom}};
        obs_q.delete();
        for (int n = 0; n < nsamp; n++) begin
            cap_rv[n] = rd_valid; cap_last[n] = rd_last; cap_idx[n] = rd_idx;
            cap_wd[n] = wr_done;  cap_rdy[n] = req_ready;
            if (rd_valid) obs_q.push_back(rd_data);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin failures++; $display("FAIL reset_rd_last got=%b exp=0", rd_last); end
        checks++; if (wr_done !== 1'b0) begin failures++; $display("FAIL reset_wr_done got=%b exp=0", wr_done); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rd_idx !== 3'd0) begin failures++; $display("FAIL reset_rd_idx got=%0d exp=0", rd_idx); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_read_timing();
        model_write(LA'(8), pack_line(32'hA000_0000));
        issue(1'b1, LA'(8), pack_line(32'hA000_0000), LAT + W + 1);
        exp_q.delete(); expect_line(LA'(8));
        issue(1'b0, LA'(8), '0, LAT + W + 1);
        for (int n = 0; n <= LAT + W; n++) begin
            logic ev;
            ev = (n >= LAT + 1) && (n <= LAT + W);
            checks++; if (cap_rv[n] !== ev) begin failures++; $display("FAIL read_rd_valid n=%0d got=%b exp=%b", n, cap_rv[n], ev); end
            checks++; if (cap_rdy[n] !== (n == LAT + W)) begin failures++; $display("FAIL read_req_ready n=%0d got=%b exp=%b", n, cap_rdy[n], n == LAT + W); end
            if (ev) begin
                checks++; if (cap_idx[n] !== 3'(n - LAT - 1)) begin failures++; $display("FAIL read_rd_idx n=%0d got=%0d exp=%0d", n, cap_idx[n], n - LAT - 1); end
                checks++; if (cap_last[n] !== (n == LAT + W)) begin failures++; $display("FAIL read_rd_last n=%0d got=%b exp=%b", n, cap_last[n], n == LAT + W); end
            end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL read_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL read_data i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_write_timing();
        model_write(LA'(8), pack_line(32'h1111_0000));
        issue(1'b1, LA'(8), pack_line(32'h1111_0000), LAT + W + 1);
        for (int n = 0; n <= LAT + W; n++) begin
            checks++; if (cap_rv[n] !== 1'b0) begin failures++; $display("FAIL write_rd_valid n=%0d got=%b exp=0", n, cap_rv[n]); end
            checks++; if (cap_wd[n] !== (n == LAT + W)) begin failures++; $display("FAIL write_wr_done n=%0d got=%b exp=%b", n, cap_wd[n], n == LAT + W); end
            checks++; if (cap_rdy[n] !== (n == LAT + W)) begin failures++; $display("FAIL write_req_ready n=%0d got=%b exp=%b", n, cap_rdy[n], n == LAT + W); end
        end
        exp_q.delete(); expect_line(LA'(8));
        issue(1'b0, LA'(8), '0, LAT + W + 1);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL wr_rd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL wr_rd_data i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [LA-1:0] lines [4];
        logic [WD-1:0] d;
        int k;
        for (int i = 0; i < 4; i++) begin
            lines[i] = LA'($urandom_range(16, 1023));
            d = rand_line();
            model_write(lines[i], d);
            issue(1'b1, lines[i], d, LAT + W + 1);
        end
        for (int t = 0; t < 10; t++) begin
            k = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = rand_line();
                model_write(lines[k], d);
                issue(1'b1, lines[k], d, LAT + W + 1);
            end else begin
                exp_q.delete(); expect_line(lines[k]);
                issue(1'b0, lines[k], '0, LAT + W + 1);
                checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count t=%0d got=%0d exp=%0d", t, obs_q.size(), exp_q.size()); end
                for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                    checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_data t=%0d i=%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WD-1:0] d;
        int guard;
        d = rand_line();
        model_write(LA'(9), d);
        issue(1'b1, LA'(9), d, LAT + W + 1);
        exp_q.delete(); expect_line(LA'(8)); expect_line(LA'(9));
        obs_q.delete();
        req_valid = 1'b1; req_we = 1'b0; req_line_addr = LA'(8);
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_line_addr = LA'(9);
        for (int n = 0; n <= 2 * (LAT + W) + 2; n++) begin
            logic er, ev;
            er = (n == LAT + W) || (n >= 2 * (LAT + W) + 1);
            ev = (n >= LAT + 1 && n <= LAT + W) ||
                 (n >= LAT + W + 1 + LAT + 1 && n <= 2 * (LAT + W) + 1);
            checks++; if (req_ready !== er) begin failures++; $display("FAIL b2b_req_ready n=%0d got=%b exp=%b", n, req_ready, er); end
            checks++; if (rd_valid !== ev) begin failures++; $display("FAIL b2b_rd_valid n=%0d got=%b exp=%b", n, rd_valid, ev); end
            if (rd_valid) obs_q.push_back(rd_data);
            if (n == LAT + W + 1) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [WD-1:0] d;
        d = pack_line(32'h2222_0000);
        // Stop sampling right after edge T+12: words 0..3 are committed, 4..7 are not.
        issue(1'b1, LA'(8), d, LAT + 4);
        rst = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL abort_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (wr_done !== 1'b0) begin failures++; $display("FAIL abort_wr_done got=%b exp=0", wr_done); end
        checks++; if (rd_last !== 1'b0) begin failures++; $display("FAIL abort_rd_last got=%b exp=0", rd_last); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL abort_rd_data got=%h exp=0", rd_data); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_req_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_mem[int'({LA'(8), 3'(i)})] = d[32*i +: 32];
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_after got=%b exp=1", req_ready); end
        exp_q.delete(); expect_line(LA'(8));
        issue(1'b0, LA'(8), '0, LAT + W + 1);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL abort_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_data i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_latency0();
        logic [WD-1:0] d;
        logic [31:0]   zw [W];
        d = rand_line();
        for (int i = 0; i < W; i++) zw[i] = d[32*i +: 32];
        checks++; if (z_req_ready !== 1'b1) begin failures++; $display("FAIL lat0_idle_ready got=%b exp=1", z_req_ready); end
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_line_addr = LA'(3); z_req_wdata = d;
        @(negedge clk);
        z_req_valid = 1'b0; z_req_wdata = '0;
        for (int n = 0; n <= W; n++) begin
            checks++; if (z_wr_done !== (n == W)) begin failures++; $display("FAIL lat0_wr_done n=%0d got=%b exp=%b", n, z_wr_done, n == W); end
            checks++; if (z_req_ready !== (n == W)) begin failures++; $display("FAIL lat0_wr_ready n=%0d got=%b exp=%b", n, z_req_ready, n == W); end
            @(negedge clk);
        end
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_line_addr = LA'(3);
        @(negedge clk);
        z_req_valid = 1'b0;
        for (int n = 0; n <= W; n++) begin
            checks++; if (z_rd_valid !== (n >= 1)) begin failures++; $display("FAIL lat0_rd_valid n=%0d got=%b exp=%b", n, z_rd_valid, n >= 1); end
            checks++; if (z_req_ready !== (n == W)) begin failures++; $display("FAIL lat0_rd_ready n=%0d got=%b exp=%b", n, z_req_ready, n == W); end
            if (n >= 1) begin
                checks++; if (z_rd_data !== zw[n-1]) begin failures++; $display("FAIL lat0_rd_data n=%0d got=%h exp=%h", n, z_rd_data, zw[n-1]); end
                checks++; if (z_rd_idx !== 3'(n - 1)) begin failures++; $display("FAIL lat0_rd_idx n=%0d got=%0d exp=%0d", n, z_rd_idx, n - 1); end
                checks++; if (z_rd_last !== (n == W)) begin failures++; $display("FAIL lat0_rd_last n=%0d got=%b exp=%b", n, z_rd_last, n == W); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stats();
`ifdef MEM_RESP_STATS_EN
        logic [WD-1:0] d;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_line_cnt !== 32'd0) begin failures++; $display("FAIL stats_rd_init got=%0d exp=0", rd_line_cnt); end
        checks++; if (wr_line_cnt !== 32'd0) begin failures++; $display("FAIL stats_wr_init got=%0d exp=0", wr_line_cnt); end
        for (int i = 0; i < 3; i++) issue(1'b0, LA'(8), '0, LAT + W + 1);
        for (int i = 0; i < 2; i++) begin
            d = rand_line();
            model_write(LA'(9), d);
            issue(1'b1, LA'(9), d, LAT + W + 1);
        end
        checks++; if (rd_line_cnt !== 32'd3) begin failures++; $display("FAIL stats_rd got=%0d exp=3", rd_line_cnt); end
        checks++; if (wr_line_cnt !== 32'd2) begin failures++; $display("FAIL stats_wr got=%0d exp=2", wr_line_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (rd_line_cnt !== 32'd0) begin failures++; $display("FAIL stats_rd_rst got=%0d exp=0", rd_line_cnt); end
        checks++; if (wr_line_cnt !== 32'd0) begin failures++; $display("FAIL stats_wr_rst got=%0d exp=0", wr_line_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_line_addr = '0; req_wdata = '0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_line_addr = '0; z_req_wdata = '0;
        test_reset();
        test_read_timing();
        test_write_timing();
        test_random();
        test_back_to_back();
        test_reset_mid_write();
        test_latency0();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
